// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
// A start/done handshake wraps an IDLE -> CHECK -> SHIFT FSM with registered outputs.
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH  = 10
) (
  input  logic                    CLOCK_50_I,
  input  logic                    resetn,
  input  logic                    start_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [BIN_WIDTH-1:0]    binary_o,
  output logic                    error_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_shifted;
  logic [SR_W-1:0]   sr_corrected;
  logic [CNT_W-1:0]  count;
  logic              digit_invalid;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sr_shifted    = sr >> 1;
    sr_corrected  = sr_shifted;
    digit_invalid = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      // Undo the doubling carry: a digit that reached 8+ after the shift had 5+ before it.
      if (sr_shifted[BIN_WIDTH + 4*d +: 4] >= 4'd8)
        sr_corrected[BIN_WIDTH + 4*d +: 4] = sr_shifted[BIN_WIDTH + 4*d +: 4] - 4'd3;
      if (sr[BIN_WIDTH + 4*d +: 4] > 4'd9)
        digit_invalid = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      sr       <= '0;
      count    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      binary_o <= '0;
      error_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            sr      <= {bcd_i, {BIN_WIDTH{1'b0}}};
            count   <= '0;
            error_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (digit_invalid) begin
            error_o  <= 1'b1;
            binary_o <= '0;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr    <= sr_corrected;
          count <= count + CNT_W'(1);
          if (count == LAST_SHIFT) begin
            binary_o <= sr_corrected[BIN_WIDTH-1:0];
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed table, handshake corner
// cases, reset abort, exhaustive valid sweep and random (possibly invalid) inputs.
module tb_bcd_to_binary_seq;

  localparam int NUM_DIGITS = 3;
  localparam int BIN_WIDTH  = 10;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int LAT_VALID  = BIN_WIDTH + 1;
  localparam int LAT_ERR    = 1;
  localparam int MAX_WAIT   = 40;

  logic                 CLOCK_50_I = 1'b0;
  logic                 resetn;
  logic                 start_i;
  logic [BCD_W-1:0]     bcd_i;
  logic                 busy_o;
  logic                 done_o;
  logic [BIN_WIDTH-1:0] binary_o;
  logic                 error_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    logic             err;
    int               bin;
    int               lat;
  } vec_t;

  vec_t vecs[6];

  bcd_to_binary_seq #(.NUM_DIGITS(NUM_DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn    (resetn),
    .start_i   (start_i),
    .bcd_i     (bcd_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .binary_o  (binary_o),
    .error_o   (error_o)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Decimal value of a packed BCD word, plus whether any digit is out of range.
  task automatic ref_model(input logic [BCD_W-1:0] bcd, output logic err, output int val);
    int d;
    err = 1'b0;
    val = 0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) err = 1'b1;
      val = val * 10 + d;
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic run_conv(input logic [BCD_W-1:0] bcd, input logic exp_err,
                          input int exp_bin, input int exp_lat);
    int lat;
    string tag;
    tag = $sformatf("%03h", bcd);
    bcd_i   = bcd;
    start_i = 1'b1;
    @(posedge CLOCK_50_I);
    @(negedge CLOCK_50_I);
    start_i = 1'b0;
    check({"busy_at_load ", tag}, 32'(busy_o), 32'd1);
    check({"err_clr_at_load ", tag}, 32'(error_o), 32'd0);
    lat = 0;
    while (done_o !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge CLOCK_50_I);
      lat++;
    end
    check({"latency ", tag}, 32'(lat), 32'(exp_lat));
    check({"binary ", tag}, 32'(binary_o), exp_err ? 32'd0 : 32'(exp_bin));
    check({"error ", tag}, 32'(error_o), 32'(exp_err));
    check({"busy_at_done ", tag}, 32'(busy_o), 32'd0);
    if (!exp_err)
      check({"bcd_part_zero ", tag}, 32'(dut.sr[BIN_WIDTH +: BCD_W]), 32'd0);
    @(negedge CLOCK_50_I);
    check({"done_width ", tag}, 32'(done_o), 32'd0);
    check({"error_hold ", tag}, 32'(error_o), 32'(exp_err));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             err;
    int               val;
    int               ndone;
    int               done_at;
    int               last;
    int               n;
    logic [BCD_W-1:0] bcd;

    vecs[0] = '{12'h999, 1'b0, 999, LAT_VALID};
    vecs[1] = '{12'h000, 1'b0, 0,   LAT_VALID};
    vecs[2] = '{12'h255, 1'b0, 255, LAT_VALID};
    vecs[3] = '{12'h100, 1'b0, 100, LAT_VALID};
    vecs[4] = '{12'h1A3, 1'b1, 0,   LAT_ERR};
    vecs[5] = '{12'h042, 1'b0, 42,  LAT_VALID};

    resetn  = 1'b0;
    start_i = 1'b0;
    bcd_i   = '0;
    #5;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_binary", 32'(binary_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    repeat (2) @(negedge CLOCK_50_I);
    resetn = 1'b1;

    foreach (vecs[i]) run_conv(vecs[i].bcd, vecs[i].err, vecs[i].bin, vecs[i].lat);

    repeat (3) @(negedge CLOCK_50_I);
    check("idle_hold_binary", 32'(binary_o), 32'd42);
    check("idle_hold_busy", 32'(busy_o), 32'd0);

    // Starts during a conversion must be ignored, not queued.
    bcd_i   = 12'h123;
    start_i = 1'b1;
    ndone   = 0;
    done_at = -1;
    for (int k = 0; k <= 24; k++) begin
      @(negedge CLOCK_50_I);
      start_i = (k == 2 || k == 6);
      bcd_i   = (k == 2 || k == 6) ? 12'h999 : 12'h123;
      if (done_o) begin
        ndone++;
        done_at = k;
        check("ignored_start_binary", 32'(binary_o), 32'd123);
      end
    end
    check("ignored_start_ndone", 32'(ndone), 32'd1);
    check("ignored_start_edge", 32'(done_at), 32'(LAT_VALID));

    // Held start re-triggers every BIN_WIDTH+2 cycles.
    bcd_i   = 12'h007;
    start_i = 1'b1;
    ndone   = 0;
    last    = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge CLOCK_50_I);
      if (done_o) begin
        ndone++;
        check("held_binary", 32'(binary_o), 32'd7);
        if (ndone == 1) check("held_first_edge", 32'(k), 32'(LAT_VALID));
        else            check("held_period", 32'(k - last), 32'(BIN_WIDTH + 2));
        last = k;
      end
    end
    start_i = 1'b0;
    check("held_ndone", 32'(ndone), 32'd3);
    n = 0;
    while (busy_o === 1'b1 && n < MAX_WAIT) begin
      @(negedge CLOCK_50_I);
      n++;
    end
    check("held_drain_timeout", 32'(n < MAX_WAIT), 32'd1);
    @(negedge CLOCK_50_I);

    // Asynchronous reset mid-conversion.
    bcd_i   = 12'h999;
    start_i = 1'b1;
    @(posedge CLOCK_50_I);
    @(negedge CLOCK_50_I);
    start_i = 1'b0;
    repeat (5) @(posedge CLOCK_50_I);
    #2;
    check("pre_abort_busy", 32'(busy_o), 32'd1);
    resetn = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_binary", 32'(binary_o), 32'd0);
    check("abort_error", 32'(error_o), 32'd0);
    repeat (2) @(negedge CLOCK_50_I);
    check("abort_no_done", 32'(done_o), 32'd0);
    resetn = 1'b1;
    run_conv(12'h010, 1'b0, 10, LAT_VALID);

    // Exhaustive sweep of valid three-digit inputs against their decimal value.
    for (int v = 0; v < 1000; v++) begin
      val = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        bcd[4*i +: 4] = 4'(val % 10);
        val = val / 10;
      end
      run_conv(bcd, 1'b0, v, LAT_VALID);
    end

    // Random raw words, many with out-of-range digits.
    for (int r = 0; r < 100; r++) begin
      bcd = BCD_W'($urandom_range(0, (1 << BCD_W) - 1));
      ref_model(bcd, err, val);
      run_conv(bcd, err, val, err ? LAT_ERR : LAT_VALID);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
